// File: rtl/twocars_pkg.sv
// Shared definitions for the 2CARS obstacle path: FSM states, lane/kind
// encodings and the screen geometry defaults also used by the renderer.
package twocars_pkg;

    localparam int DEF_Y_W      = 10;
    localparam int DEF_SCREEN_H = 480;

    typedef enum logic [1:0] {IDLE, MOVE, SPAWN, LEVEL} state_t;

    // Lanes 0-1 belong to the left car, 2-3 to the right car.
    typedef enum logic [1:0] {
        LANE_L0 = 2'd0,
        LANE_L1 = 2'd1,
        LANE_R0 = 2'd2,
        LANE_R1 = 2'd3
    } lane_t;

    typedef enum logic {
        KIND_CIRCLE = 1'b0,
        KIND_SQUARE = 1'b1
    } kind_t;

endpackage

// File: rtl/slot_prio_enc.sv
// Lowest-set-bit priority encoder: reports whether any request bit is set
// and the index of the lowest one.
module slot_prio_enc #(
    parameter int N     = 8,
    parameter int IDX_W = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]     free,
    output logic             found,
    output logic [IDX_W-1:0] idx
);

    always_comb begin
        found = 1'b0;
        idx   = '0;
        // Scan downwards so the lowest free slot is the last one to win.
        for (int i = N - 1; i >= 0; i--) begin
            if (free[i]) begin
                found = 1'b1;
                idx   = IDX_W'(i);
            end
        end
    end

endmodule

// File: rtl/obstacle_scheduler.sv
// Per-frame obstacle table sequencer: moves/retires every active slot, then
// spawns from the LFSR value, then advances the level/speed counter.
module obstacle_scheduler
    import twocars_pkg::*;
#(
    parameter int NUM_SLOTS    = 8,
    parameter int Y_W          = DEF_Y_W,
    parameter int SCREEN_H     = DEF_SCREEN_H,
    parameter int INIT_SPEED   = 2,
    parameter int MAX_SPEED    = 8,
    parameter int LEVEL_FRAMES = 600,
    parameter int MIN_GAP      = 20,
    parameter int GAP_STEP     = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     frame_tick,
    input  logic                     game_en,
    input  logic                     restart,
    input  logic [4:0]               rand_in,
    output logic [NUM_SLOTS-1:0]     obj_valid,
    output logic [2*NUM_SLOTS-1:0]   obj_lane,
    output logic [NUM_SLOTS-1:0]     obj_kind,
    output logic [Y_W*NUM_SLOTS-1:0] obj_y,
    output logic [3:0]               speed,
    output logic                     busy,
    output logic                     miss,
    output logic                     drop,
    output logic                     overrun
);

    localparam int IDX_W   = (NUM_SLOTS > 1) ? $clog2(NUM_SLOTS) : 1;
    localparam int GAP_MAX = MIN_GAP + 3 * GAP_STEP;
    localparam int GAP_W   = (GAP_MAX > 1) ? $clog2(GAP_MAX + 1) : 1;
    localparam int FC_W    = (LEVEL_FRAMES > 1) ? $clog2(LEVEL_FRAMES) : 1;

    state_t           state;
    logic [IDX_W-1:0] idx;
    logic [1:0]       lane_q [NUM_SLOTS];
    logic [Y_W-1:0]   y_q    [NUM_SLOTS];
    logic [GAP_W-1:0] spawn_cnt;
    logic [FC_W-1:0]  frame_cnt;
    logic             found;
    logic [IDX_W-1:0] free_idx;
    logic [Y_W:0]     sum;
    logic             retire;

    slot_prio_enc #(.N(NUM_SLOTS), .IDX_W(IDX_W)) u_prio (
        .free  (~obj_valid),
        .found (found),
        .idx   (free_idx)
    );

    // One extra bit so y + speed can never wrap back on screen.
    assign sum    = {1'b0, y_q[idx]} + (Y_W+1)'(speed);
    assign retire = (sum >= (Y_W+1)'(SCREEN_H));
    assign miss   = (state == MOVE) && obj_valid[idx] && retire &&
                    (obj_kind[idx] == KIND_CIRCLE);
    assign drop   = (state == SPAWN) && (spawn_cnt == '0) && !found;

    for (genvar g = 0; g < NUM_SLOTS; g++) begin : g_flat
        assign obj_lane[2*g +: 2]  = lane_q[g];
        assign obj_y[g*Y_W +: Y_W] = y_q[g];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            idx       <= '0;
            busy      <= 1'b0;
            overrun   <= 1'b0;
            speed     <= 4'(INIT_SPEED);
            spawn_cnt <= GAP_W'(MIN_GAP);
            frame_cnt <= '0;
            obj_valid <= '0;
            obj_kind  <= '0;
            for (int i = 0; i < NUM_SLOTS; i++) begin
                lane_q[i] <= '0;
                y_q[i]    <= '0;
            end
        end else begin
            if (state != IDLE && frame_tick) overrun <= 1'b1;
            case (state)
                IDLE: begin
                    if (restart) begin
                        overrun   <= 1'b0;
                        speed     <= 4'(INIT_SPEED);
                        spawn_cnt <= GAP_W'(MIN_GAP);
                        frame_cnt <= '0;
                        obj_valid <= '0;
                        obj_kind  <= '0;
                        for (int i = 0; i < NUM_SLOTS; i++) begin
                            lane_q[i] <= '0;
                            y_q[i]    <= '0;
                        end
                    end else if (frame_tick && game_en) begin
                        state <= MOVE;
                        idx   <= '0;
                        busy  <= 1'b1;
                    end
                end
                MOVE: begin
                    if (obj_valid[idx]) begin
                        if (retire) begin
                            obj_valid[idx] <= 1'b0;
                            y_q[idx]       <= '0;
                        end else begin
                            y_q[idx] <= sum[Y_W-1:0];
                        end
                    end
                    if (idx == IDX_W'(NUM_SLOTS - 1)) state <= SPAWN;
                    else                              idx   <= idx + 1'b1;
                end
                SPAWN: begin
                    // The gap reloads even when the table is full.
                    if (spawn_cnt == '0) begin
                        spawn_cnt <= GAP_W'(MIN_GAP + int'(rand_in[4:3]) * GAP_STEP);
                        if (found) begin
                            obj_valid[free_idx] <= 1'b1;
                            lane_q[free_idx]    <= rand_in[1:0];
                            obj_kind[free_idx]  <= rand_in[2];
                            y_q[free_idx]       <= '0;
                        end
                    end else begin
                        spawn_cnt <= spawn_cnt - 1'b1;
                    end
                    state <= LEVEL;
                end
                LEVEL: begin
                    if (frame_cnt == FC_W'(LEVEL_FRAMES - 1)) begin
                        frame_cnt <= '0;
                        if (speed < 4'(MAX_SPEED)) speed <= speed + 1'b1;
                    end else begin
                        frame_cnt <= frame_cnt + 1'b1;
                    end
                    state <= IDLE;
                    busy  <= 1'b0;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
